// File: rtl/ghost_pkg.sv
// Shared ghost/maze definitions used by the ghost mover, the sprite renderer
// and the Pac-Man controller.
package ghost_pkg;

    localparam int TILE_W       = 5;
    localparam int DEFAULT_COLS = 21;
    localparam int DEFAULT_ROWS = 21;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        LEFT  = 2'd1,
        DOWN  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    // Opposite heading of d.
    function automatic dir_t reverse(input dir_t d);
        case (d)
            UP:      return DOWN;
            LEFT:    return RIGHT;
            DOWN:    return UP;
            RIGHT:   return LEFT;
            default: return LEFT;
        endcase
    endfunction

endpackage

// File: rtl/ghost_dir_select.sv
// Combinational heading choice: masks the reverse heading out of the open
// set (unless it is the only way out) and picks the candidate neighbour that
// is closest to Pac-Man, ties resolved UP > LEFT > DOWN > RIGHT.
module ghost_dir_select
    import ghost_pkg::*;
(
    input  logic [3:0]        open,
    input  logic [TILE_W-1:0] pos_x,
    input  logic [TILE_W-1:0] pos_y,
    input  dir_t              ghost_dir,
    input  logic [TILE_W-1:0] pac_x,
    input  logic [TILE_W-1:0] pac_y,
    output dir_t              next_dir,
    output logic              move_valid
);

    localparam logic [TILE_W-1:0] ONE_T = TILE_W'(1);

    logic [TILE_W-1:0] nbr_x_s [4];
    logic [TILE_W-1:0] nbr_y_s [4];
    logic [TILE_W:0]   dist_s  [4];
    logic [3:0]        rev_mask_s;
    logic [3:0]        fwd_s;
    logic [3:0]        cand_s;
    logic [TILE_W:0]   best_dist_s;
    logic              found_s;
    dir_t              best_dir_s;

    // Manhattan distance between two tiles, kept one bit wider than a tile.
    function automatic logic [TILE_W:0] tile_dist(
        input logic [TILE_W-1:0] ax,
        input logic [TILE_W-1:0] ay,
        input logic [TILE_W-1:0] bx,
        input logic [TILE_W-1:0] by
    );
        logic [TILE_W-1:0] dx;
        logic [TILE_W-1:0] dy;
        dx = (ax >= bx) ? (ax - bx) : (bx - ax);
        dy = (ay >= by) ? (ay - by) : (by - ay);
        return {1'b0, dx} + {1'b0, dy};
    endfunction

    // Neighbour tiles and their distances to Pac-Man; out-of-maze
    // neighbours wrap here but are never open, so they are never chosen.
    always_comb begin
        nbr_x_s[0] = pos_x;         nbr_y_s[0] = pos_y - ONE_T;
        nbr_x_s[1] = pos_x - ONE_T; nbr_y_s[1] = pos_y;
        nbr_x_s[2] = pos_x;         nbr_y_s[2] = pos_y + ONE_T;
        nbr_x_s[3] = pos_x + ONE_T; nbr_y_s[3] = pos_y;
        for (int d = 0; d < 4; d++) begin
            dist_s[d] = tile_dist(nbr_x_s[d], nbr_y_s[d], pac_x, pac_y);
        end
    end

    // Candidate masking and strict-less-than scan in priority order.
    always_comb begin
        rev_mask_s = 4'b0000;
        rev_mask_s[reverse(ghost_dir)] = 1'b1;
        fwd_s = open & ~rev_mask_s;
        if (fwd_s != 4'b0000) begin
            cand_s = fwd_s;
        end else begin
            cand_s = open & rev_mask_s;
        end
        found_s     = 1'b0;
        best_dist_s = {(TILE_W+1){1'b1}};
        best_dir_s  = UP;
        for (int d = 0; d < 4; d++) begin
            if (cand_s[d] && (!found_s || (dist_s[d] < best_dist_s))) begin
                found_s     = 1'b1;
                best_dist_s = dist_s[d];
                best_dir_s  = dir_t'(d[1:0]);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
        next_dir   = best_dir_s;
        move_valid = found_s;
    end

endmodule

// File: rtl/ghost_mover.sv
// Per-ghost movement controller: on each move tick probes the four
// neighbouring tiles through a synchronous wall-map port, greedily steps one
// tile towards Pac-Man and reports a catch when both share a tile.
module ghost_mover
    import ghost_pkg::*;
#(
    parameter int COLS    = DEFAULT_COLS,
    parameter int ROWS    = DEFAULT_ROWS,
    parameter int START_X = 10,
    parameter int START_Y = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              move_tick,
    input  logic              gameover,
    input  logic [TILE_W-1:0] pac_x,
    input  logic [TILE_W-1:0] pac_y,
    output logic [TILE_W-1:0] wall_rd_x,
    output logic [TILE_W-1:0] wall_rd_y,
    input  logic              wall_bit,
    output logic [TILE_W-1:0] ghost_x,
    output logic [TILE_W-1:0] ghost_y,
    output dir_t              ghost_dir,
    output logic              busy,
    output logic              caught
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PROBE_U = 3'd1,
        PROBE_L = 3'd2,
        PROBE_D = 3'd3,
        PROBE_R = 3'd4,
        CAPTURE = 3'd5,
        DECIDE  = 3'd6
    } state_t;

    localparam logic [TILE_W-1:0] MAX_X   = TILE_W'(COLS - 1);
    localparam logic [TILE_W-1:0] MAX_Y   = TILE_W'(ROWS - 1);
    localparam logic [TILE_W-1:0] ZERO_T  = TILE_W'(0);
    localparam logic [TILE_W-1:0] ONE_T   = TILE_W'(1);
    localparam logic [TILE_W-1:0] START_X_T = TILE_W'(START_X);
    localparam logic [TILE_W-1:0] START_Y_T = TILE_W'(START_Y);

    state_t            state_r;
    state_t            state_s;
    logic [TILE_W-1:0] ghost_x_r;
    logic [TILE_W-1:0] ghost_y_r;
    dir_t              ghost_dir_r;
    logic              busy_r;
    logic              caught_r;
    logic [TILE_W-1:0] wall_rd_x_r;
    logic [TILE_W-1:0] wall_rd_y_r;
    logic [3:0]        open_r;

    logic [TILE_W-1:0] nbr_x_s [4];
    logic [TILE_W-1:0] nbr_y_s [4];
    logic [3:0]        oob_s;
    logic              probe_en_s;
    logic [1:0]        probe_idx_s;
    logic [TILE_W-1:0] probe_x_s;
    logic [TILE_W-1:0] probe_y_s;
    dir_t              next_dir_s;
    logic              move_valid_s;

    ghost_dir_select u_dir_select (
        .open       (open_r),
        .pos_x      (ghost_x_r),
        .pos_y      (ghost_y_r),
        .ghost_dir  (ghost_dir_r),
        .pac_x      (pac_x),
        .pac_y      (pac_y),
        .next_dir   (next_dir_s),
        .move_valid (move_valid_s)
    );

    // Neighbour coordinates and the maze-edge flags (no wrap-around tunnels).
    always_comb begin
        nbr_x_s[0] = ghost_x_r;         nbr_y_s[0] = ghost_y_r - ONE_T;
        nbr_x_s[1] = ghost_x_r - ONE_T; nbr_y_s[1] = ghost_y_r;
        nbr_x_s[2] = ghost_x_r;         nbr_y_s[2] = ghost_y_r + ONE_T;
        nbr_x_s[3] = ghost_x_r + ONE_T; nbr_y_s[3] = ghost_y_r;
        oob_s[0] = (ghost_y_r == ZERO_T);
        oob_s[1] = (ghost_x_r == ZERO_T);
        oob_s[2] = (ghost_y_r == MAX_Y);
        oob_s[3] = (ghost_x_r == MAX_X);
    end

    // Next-state logic: one probe per direction, then capture and decide.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (move_tick && !gameover) begin
                    state_s = PROBE_U;
                end else begin
                    state_s = IDLE;
                end
            end
            PROBE_U: state_s = PROBE_L;
            PROBE_L: state_s = PROBE_D;
            PROBE_D: state_s = PROBE_R;
            PROBE_R: state_s = CAPTURE;
            CAPTURE: state_s = DECIDE;
            DECIDE:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Address to present during the upcoming probe state; an off-maze
    // neighbour reads the current tile instead.
    always_comb begin
        probe_en_s  = 1'b0;
        probe_idx_s = 2'd0;
        case (state_s)
            PROBE_U: begin probe_en_s = 1'b1; probe_idx_s = 2'd0; end
            PROBE_L: begin probe_en_s = 1'b1; probe_idx_s = 2'd1; end
            PROBE_D: begin probe_en_s = 1'b1; probe_idx_s = 2'd2; end
            PROBE_R: begin probe_en_s = 1'b1; probe_idx_s = 2'd3; end
            default: begin probe_en_s = 1'b0; probe_idx_s = 2'd0; end
        endcase
        if (oob_s[probe_idx_s]) begin
            probe_x_s = ghost_x_r;
            probe_y_s = ghost_y_r;
        end else begin
            probe_x_s = nbr_x_s[probe_idx_s];
            probe_y_s = nbr_y_s[probe_idx_s];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered wall-map address, loaded one cycle ahead of each probe state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wall_rd_x_r <= ZERO_T;
            wall_rd_y_r <= ZERO_T;
        end else if (probe_en_s) begin
            wall_rd_x_r <= probe_x_s;
            wall_rd_y_r <= probe_y_s;
        end
    end

    // Capture read data one state after each probe, then commit the step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            open_r      <= 4'b0000;
            ghost_x_r   <= START_X_T;
            ghost_y_r   <= START_Y_T;
            ghost_dir_r <= LEFT;
        end else begin
            case (state_r)
                PROBE_L: open_r[0] <= !wall_bit && !oob_s[0];
                PROBE_D: open_r[1] <= !wall_bit && !oob_s[1];
                PROBE_R: open_r[2] <= !wall_bit && !oob_s[2];
                CAPTURE: open_r[3] <= !wall_bit && !oob_s[3];
                DECIDE: begin
                    if (move_valid_s) begin
                        ghost_x_r   <= nbr_x_s[next_dir_s];
                        ghost_y_r   <= nbr_y_s[next_dir_s];
                        ghost_dir_r <= next_dir_s;
                    end
                end
                default: open_r <= open_r;
            endcase
        end
    end

    // Status flags: busy tracks the non-idle states, caught lags position by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r   <= 1'b0;
            caught_r <= 1'b0;
        end else begin
            busy_r   <= (state_s != IDLE);
            caught_r <= (ghost_x_r == pac_x) && (ghost_y_r == pac_y) && !gameover;
        end
    end

    assign wall_rd_x = wall_rd_x_r;
    assign wall_rd_y = wall_rd_y_r;
    assign ghost_x   = ghost_x_r;
    assign ghost_y   = ghost_y_r;
    assign ghost_dir = ghost_dir_r;
    assign busy      = busy_r;
    assign caught    = caught_r;

endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover: three instances with different start tiles
// share the control inputs, each with its own synchronous wall-map model.
module tb_ghost_mover;
    import ghost_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       move_tick;
    logic       gameover;
    logic [4:0] pac_x;
    logic [4:0] pac_y;

    logic [4:0] rd_x_a, rd_y_a, gx_a, gy_a;
    logic [4:0] rd_x_b, rd_y_b, gx_b, gy_b;
    logic [4:0] rd_x_c, rd_y_c, gx_c, gy_c;
    logic       wb_a, wb_b, wb_c;
    dir_t       gd_a, gd_b, gd_c;
    logic       busy_a, busy_b, busy_c;
    logic       caught_a, caught_b, caught_c;

    logic       wall_map [32][32];
    logic [4:0] log_ax [4];
    logic [4:0] log_ay [4];
    logic [4:0] log_cx [4];
    logic [4:0] log_cy [4];

    int checks;
    int errors;

    ghost_mover dut_a (
        .clk(clk), .reset_n(reset_n), .move_tick(move_tick), .gameover(gameover),
        .pac_x(pac_x), .pac_y(pac_y), .wall_rd_x(rd_x_a), .wall_rd_y(rd_y_a),
        .wall_bit(wb_a), .ghost_x(gx_a), .ghost_y(gy_a), .ghost_dir(gd_a),
        .busy(busy_a), .caught(caught_a)
    );

    ghost_mover #(.START_X(5), .START_Y(5)) dut_b (
        .clk(clk), .reset_n(reset_n), .move_tick(move_tick), .gameover(gameover),
        .pac_x(pac_x), .pac_y(pac_y), .wall_rd_x(rd_x_b), .wall_rd_y(rd_y_b),
        .wall_bit(wb_b), .ghost_x(gx_b), .ghost_y(gy_b), .ghost_dir(gd_b),
        .busy(busy_b), .caught(caught_b)
    );

    ghost_mover #(.START_X(0), .START_Y(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .move_tick(move_tick), .gameover(gameover),
        .pac_x(pac_x), .pac_y(pac_y), .wall_rd_x(rd_x_c), .wall_rd_y(rd_y_c),
        .wall_bit(wb_c), .ghost_x(gx_c), .ghost_y(gy_c), .ghost_dir(gd_c),
        .busy(busy_c), .caught(caught_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous wall-map ROM: data valid one cycle after the address.
    always @(posedge clk) begin
        wb_a <= wall_map[rd_x_a][rd_y_a];
        wb_b <= wall_map[rd_x_b][rd_y_b];
        wb_c <= wall_map[rd_x_c][rd_y_c];
    end

    task automatic clear_walls();
        for (int x = 0; x < 32; x++) begin
            for (int y = 0; y < 32; y++) begin
                wall_map[x][y] = 1'b0;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        move_tick = 1'b0;
        gameover  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One tick pulse, then follow busy (bounded), logging the probe addresses.
    task automatic run_step(output int n);
        n = 0;
        @(negedge clk);
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        while (busy_a && n < 20) begin
            if (n < 4) begin
                log_ax[n] = rd_x_a; log_ay[n] = rd_y_a;
                log_cx[n] = rd_x_c; log_cy[n] = rd_y_c;
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        pac_x = 5'd0; pac_y = 5'd20;
        clear_walls();
        apply_reset();
        checks++; if (gx_a !== 5'd10 || gy_a !== 5'd9) begin errors++; $display("FAIL reset_pos: got (%0d,%0d) expected (10,9)", gx_a, gy_a); end
        checks++; if (gd_a !== LEFT) begin errors++; $display("FAIL reset_dir: got %0d expected %0d", gd_a, LEFT); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (caught_a !== 1'b0) begin errors++; $display("FAIL reset_caught: got %b expected 0", caught_a); end
        checks++; if (rd_x_a !== 5'd0 || rd_y_a !== 5'd0) begin errors++; $display("FAIL reset_rdaddr: got (%0d,%0d) expected (0,0)", rd_x_a, rd_y_a); end
    endtask

    task automatic test_open_corridor();
        int n;
        logic [4:0] ex [4];
        logic [4:0] ey [4];
        ex[0] = 5'd10; ey[0] = 5'd8;
        ex[1] = 5'd9;  ey[1] = 5'd9;
        ex[2] = 5'd10; ey[2] = 5'd10;
        ex[3] = 5'd11; ey[3] = 5'd9;
        pac_x = 5'd10; pac_y = 5'd2;
        clear_walls();
        apply_reset();
        run_step(n);
        checks++; if (n !== 6) begin errors++; $display("FAIL corridor_busy_cycles: got %0d expected 6", n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_ax[i] !== ex[i] || log_ay[i] !== ey[i]) begin
                errors++;
                $display("FAIL corridor_probe_addr[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, log_ax[i], log_ay[i], ex[i], ey[i]);
            end
        end
        checks++; if (gx_a !== 5'd10 || gy_a !== 5'd8) begin errors++; $display("FAIL corridor_pos: got (%0d,%0d) expected (10,8)", gx_a, gy_a); end
        checks++; if (gd_a !== UP) begin errors++; $display("FAIL corridor_dir: got %0d expected %0d", gd_a, UP); end
    endtask

    task automatic test_tie_break();
        int n;
        pac_x = 5'd9; pac_y = 5'd8;
        clear_walls();
        apply_reset();
        run_step(n);
        checks++; if (gx_a !== 5'd10 || gy_a !== 5'd8 || gd_a !== UP) begin errors++; $display("FAIL tie_up_over_left: got (%0d,%0d) dir %0d expected (10,8) dir %0d", gx_a, gy_a, gd_a, UP); end
    endtask

    task automatic test_no_reverse();
        int n;
        pac_x = 5'd9; pac_y = 5'd5;
        clear_walls();
        wall_map[4][5] = 1'b1;
        wall_map[5][6] = 1'b1;
        apply_reset();
        run_step(n);
        checks++; if (gx_b !== 5'd5 || gy_b !== 5'd4) begin errors++; $display("FAIL no_reverse_pos: got (%0d,%0d) expected (5,4)", gx_b, gy_b); end
        checks++; if (gd_b !== UP) begin errors++; $display("FAIL no_reverse_dir: got %0d expected %0d", gd_b, UP); end
    endtask

    task automatic test_dead_end();
        int n;
        pac_x = 5'd0; pac_y = 5'd5;
        clear_walls();
        wall_map[4][5] = 1'b1;
        wall_map[5][6] = 1'b1;
        wall_map[5][4] = 1'b1;
        apply_reset();
        run_step(n);
        checks++; if (gx_b !== 5'd6 || gy_b !== 5'd5) begin errors++; $display("FAIL dead_end_pos: got (%0d,%0d) expected (6,5)", gx_b, gy_b); end
        checks++; if (gd_b !== RIGHT) begin errors++; $display("FAIL dead_end_dir: got %0d expected %0d", gd_b, RIGHT); end
    endtask

    task automatic test_edge();
        int n;
        pac_x = 5'd3; pac_y = 5'd3;
        clear_walls();
        apply_reset();
        run_step(n);
        checks++; if (log_cx[0] !== 5'd0 || log_cy[0] !== 5'd0 || log_cx[1] !== 5'd0 || log_cy[1] !== 5'd0) begin
            errors++; $display("FAIL edge_probe_addr: got U(%0d,%0d) L(%0d,%0d) expected (0,0) for both", log_cx[0], log_cy[0], log_cx[1], log_cy[1]);
        end
        checks++; if (gx_c !== 5'd0 || gy_c !== 5'd1 || gd_c !== DOWN) begin errors++; $display("FAIL edge_tie_down: got (%0d,%0d) dir %0d expected (0,1) dir %0d", gx_c, gy_c, gd_c, DOWN); end
        // Corner with both in-maze neighbours walled: edges must not count as open.
        clear_walls();
        wall_map[0][1] = 1'b1;
        wall_map[1][0] = 1'b1;
        apply_reset();
        run_step(n);
        checks++; if (gx_c !== 5'd0 || gy_c !== 5'd0 || gd_c !== LEFT) begin errors++; $display("FAIL edge_boxed_hold: got (%0d,%0d) dir %0d expected (0,0) dir %0d", gx_c, gy_c, gd_c, LEFT); end
    endtask

    task automatic test_back_to_back();
        int n;
        int extra_busy;
        pac_x = 5'd10; pac_y = 5'd2;
        clear_walls();
        apply_reset();
        @(negedge clk); move_tick = 1'b1;     // T
        @(negedge clk); move_tick = 1'b0;     // T+1
        @(negedge clk);                       // T+2
        @(negedge clk); move_tick = 1'b1;     // T+3
        @(negedge clk); move_tick = 1'b0;     // T+4
        n = 0;
        while (busy_a && n < 20) begin n++; @(negedge clk); end
        extra_busy = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy_a) extra_busy++;
            @(negedge clk);
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_busy_remaining: got %0d expected 3", n); end
        checks++; if (extra_busy !== 0) begin errors++; $display("FAIL b2b_dropped_tick: got %0d busy cycles expected 0", extra_busy); end
        checks++; if (gx_a !== 5'd10 || gy_a !== 5'd8) begin errors++; $display("FAIL b2b_single_step: got (%0d,%0d) expected (10,8)", gx_a, gy_a); end
    endtask

    task automatic test_catch_gameover();
        int n;
        pac_x = 5'd10; pac_y = 5'd8;
        clear_walls();
        apply_reset();
        run_step(n);
        checks++; if (gx_a !== 5'd10 || gy_a !== 5'd8 || caught_a !== 1'b0) begin errors++; $display("FAIL catch_lag: got (%0d,%0d) caught %b expected (10,8) caught 0", gx_a, gy_a, caught_a); end
        @(negedge clk);
        checks++; if (caught_a !== 1'b1) begin errors++; $display("FAIL catch_set: got %b expected 1", caught_a); end
        gameover = 1'b1;
        @(negedge clk);
        checks++; if (caught_a !== 1'b0) begin errors++; $display("FAIL gameover_caught: got %b expected 0", caught_a); end
        pac_x = 5'd10; pac_y = 5'd2;
        run_step(n);
        checks++; if (n !== 0 || gx_a !== 5'd10 || gy_a !== 5'd8) begin errors++; $display("FAIL gameover_frozen: got busy %0d pos (%0d,%0d) expected busy 0 pos (10,8)", n, gx_a, gy_a); end
        pac_x = 5'd10; pac_y = 5'd8;
        gameover = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (caught_a !== 1'b1) begin errors++; $display("FAIL catch_after_gameover: got %b expected 1", caught_a); end
    endtask

    task automatic test_reset_mid_step();
        int n;
        pac_x = 5'd10; pac_y = 5'd2;
        clear_walls();
        apply_reset();
        @(negedge clk); move_tick = 1'b1;     // T
        @(negedge clk); move_tick = 1'b0;     // T+1 PROBE_U
        @(negedge clk);                       // T+2 PROBE_L
        @(negedge clk); reset_n = 1'b0;       // T+3 PROBE_D
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        checks++; if (gx_a !== 5'd10 || gy_a !== 5'd9 || gd_a !== LEFT) begin errors++; $display("FAIL midreset_state: got (%0d,%0d) dir %0d expected (10,9) dir %0d", gx_a, gy_a, gd_a, LEFT); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy_a); end
        run_step(n);
        checks++; if (n !== 6 || gx_a !== 5'd10 || gy_a !== 5'd8 || gd_a !== UP) begin errors++; $display("FAIL midreset_next_step: got busy %0d pos (%0d,%0d) dir %0d expected busy 6 pos (10,8) dir %0d", n, gx_a, gy_a, gd_a, UP); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        move_tick = 1'b0;
        gameover  = 1'b0;
        pac_x     = 5'd0;
        pac_y     = 5'd0;
        clear_walls();
        test_reset();
        test_open_corridor();
        test_tie_break();
        test_no_reverse();
        test_dead_end();
        test_edge();
        test_back_to_back();
        test_catch_gameover();
        test_reset_mid_step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
